// File: rtl/ff_test_sweep_master.sv
// Phase-sweep test master: init-writes the DUT, then reads one probability count per phase point
// over a strobe/ready native bus, stepping the phase between points. Option: FF_SWEEP_PHASE_RETURN_EN.
module ff_test_sweep_master #(
  parameter int          NATIVE_ADDR_WDITH = 3,
  parameter int          NATIVE_DATA_WIDTH = 32,
  parameter logic [31:0] TIMEOUT           = 32'd1000000
) (
  input  logic                         NATIVE_CLK,
  input  logic                         rst_n,
  input  logic                         cmd_start,
  input  logic [15:0]                  cmd_steps,
  input  logic                         cmd_incdec,
  input  logic                         cmd_init,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         NATIVE_EN,
  output logic                         NATIVE_WR,
  output logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR,
  output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_WDATA,
  input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_RDATA,
  input  logic                         NATIVE_READY,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_data,
  output logic [15:0]                  res_index
);

  typedef enum logic [3:0] {
    IDLE, INIT_WR, INIT_WT, TEST_RD, TEST_WT, CAPT, PUSH, PS_WR, PS_WT, FIN, ERR
`ifdef FF_SWEEP_PHASE_RETURN_EN
    , RET_WR, RET_WT
`endif
  } state_t;

  localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_PHASE = NATIVE_ADDR_WDITH'(0);
  localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_INIT  = NATIVE_ADDR_WDITH'(1);
  localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_TEST  = NATIVE_ADDR_WDITH'(2);

  state_t      state;
  logic [15:0] steps_reg;
  logic        incdec_reg;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        more_points;
`ifdef FF_SWEEP_PHASE_RETURN_EN
  logic [15:0] ret_cnt;
`endif

  assign tmo_hit     = (tmo_cnt >= TIMEOUT - 32'd1);
  // 17-bit compare so 65535 points never wraps the index test
  assign more_points = ({1'b0, res_index} + 17'd1) < {1'b0, steps_reg};

  always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      steps_reg    <= '0;
      incdec_reg   <= 1'b0;
      tmo_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      NATIVE_EN    <= 1'b0;
      NATIVE_WR    <= 1'b0;
      NATIVE_ADDR  <= '0;
      NATIVE_WDATA <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_index    <= '0;
`ifdef FF_SWEEP_PHASE_RETURN_EN
      ret_cnt      <= '0;
`endif
    end else begin
      // Strobe and done are one-cycle pulses unless a transition re-asserts them
      NATIVE_EN <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          steps_reg    <= cmd_steps;
          incdec_reg   <= cmd_incdec;
          error        <= 1'b0;
          busy         <= 1'b1;
          res_index    <= '0;
          NATIVE_EN    <= 1'b1;
          NATIVE_WR    <= 1'b1;
          NATIVE_ADDR  <= ADDR_INIT;
          NATIVE_WDATA <= {{(NATIVE_DATA_WIDTH-1){1'b0}}, cmd_init};
          state        <= INIT_WR;
        end
        INIT_WR, TEST_RD, PS_WR
`ifdef FF_SWEEP_PHASE_RETURN_EN
        , RET_WR
`endif
        : begin
          tmo_cnt <= '0;
          state   <= state_t'(state + 4'd1);
        end
        INIT_WT, TEST_WT, PS_WT
`ifdef FF_SWEEP_PHASE_RETURN_EN
        , RET_WT
`endif
        : begin
          if (!NATIVE_READY) begin
            if (tmo_hit) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ERR;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end else if (state == TEST_WT) begin
            state <= CAPT;
          end else if ((state == INIT_WT && steps_reg != 16'd0) || state == PS_WT) begin
            if (state == PS_WT) res_index <= res_index + 16'd1;
            NATIVE_EN   <= 1'b1;
            NATIVE_WR   <= 1'b0;
            NATIVE_ADDR <= ADDR_TEST;
            state       <= TEST_RD;
`ifdef FF_SWEEP_PHASE_RETURN_EN
          end else if (state == RET_WT && ({1'b0, ret_cnt} + 17'd2) < {1'b0, steps_reg}) begin
            ret_cnt   <= ret_cnt + 16'd1;
            NATIVE_EN <= 1'b1;
            state     <= RET_WR;
`endif
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        CAPT: begin
          res_data  <= 32'(NATIVE_RDATA);
          res_valid <= 1'b1;
          state     <= PUSH;
        end
        PUSH: if (res_ready) begin
          res_valid <= 1'b0;
          if (more_points) begin
            NATIVE_EN    <= 1'b1;
            NATIVE_WR    <= 1'b1;
            NATIVE_ADDR  <= ADDR_PHASE;
            NATIVE_WDATA <= {{(NATIVE_DATA_WIDTH-1){1'b0}}, incdec_reg};
            state        <= PS_WR;
`ifdef FF_SWEEP_PHASE_RETURN_EN
          end else if (steps_reg > 16'd1) begin
            // Walk the phase back to where the sweep started
            ret_cnt      <= '0;
            NATIVE_EN    <= 1'b1;
            NATIVE_WR    <= 1'b1;
            NATIVE_ADDR  <= ADDR_PHASE;
            NATIVE_WDATA <= {{(NATIVE_DATA_WIDTH-1){1'b0}}, ~incdec_reg};
            state        <= RET_WR;
`endif
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_test_sweep_master.sv
// Directed bench for ff_test_sweep_master: bus responder with programmable latency, result sink,
// and hand-computed expectations for sweep, zero-step, stall, timeout and reset scenarios.
module tb_ff_test_sweep_master;

  logic        NATIVE_CLK = 1'b0;
  logic        rst_n, cmd_start, cmd_incdec, cmd_init, res_ready, NATIVE_READY;
  logic [15:0] cmd_steps;
  logic [31:0] NATIVE_RDATA;
  logic        busy, done, error, NATIVE_EN, NATIVE_WR, res_valid;
  logic [2:0]  NATIVE_ADDR;
  logic [31:0] NATIVE_WDATA, res_data;
  logic [15:0] res_index;

  always #5 NATIVE_CLK = ~NATIVE_CLK;

  ff_test_sweep_master #(
    .NATIVE_ADDR_WDITH(3), .NATIVE_DATA_WIDTH(32), .TIMEOUT(32'd50)
  ) dut (
    .NATIVE_CLK(NATIVE_CLK), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_steps(cmd_steps),
    .cmd_incdec(cmd_incdec), .cmd_init(cmd_init), .busy(busy), .done(done), .error(error),
    .NATIVE_EN(NATIVE_EN), .NATIVE_WR(NATIVE_WR), .NATIVE_ADDR(NATIVE_ADDR),
    .NATIVE_WDATA(NATIVE_WDATA), .NATIVE_RDATA(NATIVE_RDATA), .NATIVE_READY(NATIVE_READY),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
  );

  int n_checks, n_fail;
  int cyc, n_txn, n_res, n_done, rd_idx, en_viol, pend_cnt, ready_delay;
  int ready_cyc, done_cyc, err_cyc, strobe_cyc;
  bit pending, pend_wr, suppress_rd, en_prev, done_prev, err_prev;
  logic [31:0] txn_log[64], res_log[64], rd_vals[8], exp_t[16];

  function automatic logic [31:0] enc(input logic wr, input logic [3:0] a, input logic [23:0] d);
    return {3'b0, wr, a, d};
  endfunction

  function automatic logic [31:0] renc(input logic [15:0] i, input logic [15:0] d);
    return {i, d};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge NATIVE_CLK); #1; end
  endtask

  task automatic clear_logs();
    n_txn = 0; n_res = 0; n_done = 0; rd_idx = 0; en_viol = 0; pending = 0;
  endtask

  task automatic start_sweep(input logic [15:0] s, input logic dir, input logic ini);
    cmd_steps = s; cmd_incdec = dir; cmd_init = ini; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, k;
    base = n_done; k = 0;
    while (n_done == base && k < budget) begin step(1); k++; end
    check_val({tag, " done_seen"}, 32'(n_done != base), 32'd1);
  endtask

  task automatic check_txns(input string tag, input int n);
    check_val({tag, " n_txn"}, 32'(n_txn), 32'(n));
    for (int i = 0; i < n && i < 16; i++)
      check_val($sformatf("%s txn%0d", tag, i), txn_log[i], exp_t[i]);
  endtask

  // Bus responder and monitors, all working on the falling edge
  initial begin
    NATIVE_READY = 1'b0; NATIVE_RDATA = '0;
    forever begin
      @(negedge NATIVE_CLK);
      cyc++;
      if (!rst_n) begin
        pending = 0; NATIVE_READY = 1'b0; en_prev = 0;
      end else begin
        NATIVE_READY = 1'b0;
        if (pending) begin
          pend_cnt++;
          if (pend_cnt >= ready_delay && !(suppress_rd && !pend_wr)) begin
            NATIVE_READY = 1'b1; ready_cyc = cyc; pending = 0;
            if (!pend_wr) begin NATIVE_RDATA = rd_vals[rd_idx % 8]; rd_idx++; end
          end
        end
        if (NATIVE_EN) begin
          if (en_prev || res_valid) en_viol++;
          if (n_txn < 64) txn_log[n_txn] = enc(NATIVE_WR, 4'(NATIVE_ADDR), NATIVE_WR ? NATIVE_WDATA[23:0] : 24'd0);
          $display("txn %0d cyc=%0d wr=%0b addr=%0d wdata=%0h", n_txn, cyc, NATIVE_WR, NATIVE_ADDR, NATIVE_WDATA);
          n_txn++; pending = 1; pend_wr = NATIVE_WR; pend_cnt = 0; strobe_cyc = cyc;
        end
        en_prev = NATIVE_EN;
        if (res_valid && res_ready) begin
          if (n_res < 64) res_log[n_res] = renc(res_index, res_data[15:0]);
          $display("result %0d index=%0d data=%0d", n_res, res_index, res_data);
          n_res++;
        end
      end
      if (done) begin
        if (done_prev) en_viol++;
        n_done++; done_cyc = cyc;
      end
      done_prev = done;
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
    end
  end

  initial begin
    int nt, nr;
    logic [31:0] d0;
    logic [15:0] i0;
    int stable_bad, k;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_steps = '0; cmd_incdec = 1'b0; cmd_init = 1'b0;
    res_ready = 1'b1; ready_delay = 5; suppress_rd = 0;
    clear_logs();
    step(3);
    check_val("rst busy", 32'(busy), 0);          check_val("rst done", 32'(done), 0);
    check_val("rst error", 32'(error), 0);        check_val("rst en", 32'(NATIVE_EN), 0);
    check_val("rst wr", 32'(NATIVE_WR), 0);       check_val("rst addr", 32'(NATIVE_ADDR), 0);
    check_val("rst wdata", NATIVE_WDATA, 0);      check_val("rst valid", 32'(res_valid), 0);
    check_val("rst rdata", res_data, 0);          check_val("rst index", 32'(res_index), 0);
    rst_n = 1'b1;
    step(2);

    // Three-point sweep, second start while busy must be ignored
    clear_logs();
    rd_vals[0] = 100; rd_vals[1] = 200; rd_vals[2] = 300;
    start_sweep(16'd3, 1'b1, 1'b1);
    step(10);
    start_sweep(16'd7, 1'b0, 1'b0);
    wait_done("t1", 400);
    step(3);
    exp_t[0] = enc(1, 1, 1); exp_t[1] = enc(0, 2, 0); exp_t[2] = enc(1, 0, 1);
    exp_t[3] = enc(0, 2, 0); exp_t[4] = enc(1, 0, 1); exp_t[5] = enc(0, 2, 0);
`ifdef FF_SWEEP_PHASE_RETURN_EN
    exp_t[6] = enc(1, 0, 0); exp_t[7] = enc(1, 0, 0);
    check_txns("t1", 8);
`else
    check_txns("t1", 6);
`endif
    check_val("t1 n_res", 32'(n_res), 3);
    check_val("t1 res0", res_log[0], renc(0, 100));
    check_val("t1 res1", res_log[1], renc(1, 200));
    check_val("t1 res2", res_log[2], renc(2, 300));
    check_val("t1 n_done", 32'(n_done), 1);
    check_val("t1 busy", 32'(busy), 0);
    check_val("t1 error", 32'(error), 0);
    check_val("t1 proto", 32'(en_viol), 0);

    // Zero points: init write only, done one cycle after its completion
    clear_logs();
    start_sweep(16'd0, 1'b0, 1'b0);
    wait_done("t2", 200);
    step(3);
    exp_t[0] = enc(1, 1, 0);
    check_txns("t2", 1);
    check_val("t2 n_res", 32'(n_res), 0);
    check_val("t2 done_lat", 32'(done_cyc - ready_cyc), 1);
    check_val("t2 n_done", 32'(n_done), 1);

    // Result stall: outputs hold and no strobe while res_ready is low
    clear_logs();
    rd_vals[0] = 11; rd_vals[1] = 22;
    res_ready = 1'b0;
    start_sweep(16'd2, 1'b0, 1'b1);
    k = 0;
    while (!res_valid && k < 200) begin step(1); k++; end
    check_val("t3 valid_seen", 32'(res_valid), 1);
    d0 = res_data; i0 = res_index;
    check_val("t3 stall data", d0, 11);
    check_val("t3 stall index", 32'(i0), 0);
    nt = n_txn; stable_bad = 0;
    repeat (20) begin
      step(1);
      if (res_data !== d0 || res_index !== i0 || res_valid !== 1'b1) stable_bad++;
    end
    check_val("t3 stable", 32'(stable_bad), 0);
    check_val("t3 no_strobe", 32'(n_txn - nt), 0);
    res_ready = 1'b1;
    wait_done("t3", 400);
    step(3);
    check_val("t3 n_res", 32'(n_res), 2);
    check_val("t3 res0", res_log[0], renc(0, 11));
    check_val("t3 res1", res_log[1], renc(1, 22));
    check_val("t3 proto", 32'(en_viol), 0);

    // Read never answered: timeout after 50 wait cycles
    clear_logs();
    suppress_rd = 1;
    start_sweep(16'd2, 1'b0, 1'b0);
    wait_done("t4", 300);
    step(2);
    check_val("t4 error", 32'(error), 1);
    check_val("t4 err_lat", 32'(err_cyc - strobe_cyc), 51);
    check_val("t4 n_res", 32'(n_res), 0);
    check_val("t4 n_done", 32'(n_done), 1);
    check_val("t4 busy", 32'(busy), 0);
    check_val("t4 n_txn", 32'(n_txn), 2);
    suppress_rd = 0;
    clear_logs();
    start_sweep(16'd0, 1'b0, 1'b1);
    check_val("t4 err_clear", 32'(error), 0);
    wait_done("t4b", 200);
    step(2);
    check_val("t4b error", 32'(error), 0);
    exp_t[0] = enc(1, 1, 1);
    check_txns("t4b", 1);

    // Reset while waiting on the phase-step write
    clear_logs();
    rd_vals[0] = 7;
    start_sweep(16'd4, 1'b1, 1'b0);
    k = 0;
    while (n_txn < 3 && k < 300) begin step(1); k++; end
    check_val("t5 reach_ps", 32'(n_txn), 3);
    rst_n = 1'b0;
    #1;
    check_val("t5 busy", 32'(busy), 0);         check_val("t5 en", 32'(NATIVE_EN), 0);
    check_val("t5 valid", 32'(res_valid), 0);   check_val("t5 index", 32'(res_index), 0);
    check_val("t5 addr", 32'(NATIVE_ADDR), 0);  check_val("t5 wdata", NATIVE_WDATA, 0);
    check_val("t5 rdata", res_data, 0);         check_val("t5 wr", 32'(NATIVE_WR), 0);
    step(2);
    rst_n = 1'b1;
    nt = n_txn; nr = n_res;
    step(20);
    check_val("t5 quiet_txn", 32'(n_txn - nt), 0);
    check_val("t5 quiet_res", 32'(n_res - nr), 0);
    check_val("t5 quiet_done", 32'(n_done), 0);
    check_val("t5 idle", 32'(busy), 0);
    clear_logs();
    rd_vals[0] = 55;
    start_sweep(16'd1, 1'b0, 1'b1);
    wait_done("t5b", 200);
    step(3);
    exp_t[0] = enc(1, 1, 1); exp_t[1] = enc(0, 2, 0);
    check_txns("t5b", 2);
    check_val("t5b n_res", 32'(n_res), 1);
    check_val("t5b res0", res_log[0], renc(0, 55));

`ifdef FF_SWEEP_PHASE_RETURN_EN
    // Return walk: two steps down then two steps back
    clear_logs();
    rd_vals[0] = 1; rd_vals[1] = 2; rd_vals[2] = 3;
    start_sweep(16'd3, 1'b0, 1'b0);
    wait_done("t6", 500);
    step(3);
    exp_t[0] = enc(1, 1, 0); exp_t[1] = enc(0, 2, 0); exp_t[2] = enc(1, 0, 0);
    exp_t[3] = enc(0, 2, 0); exp_t[4] = enc(1, 0, 0); exp_t[5] = enc(0, 2, 0);
    exp_t[6] = enc(1, 0, 1); exp_t[7] = enc(1, 0, 1);
    check_txns("t6", 8);
    check_val("t6 n_res", 32'(n_res), 3);
    check_val("t6 n_done", 32'(n_done), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
